// File: rtl/daq_packetizer.sv
// daq_packetizer: sample-rate scheduler and packet framer
// for an 8-channel 16-bit parallel ADC front end.
module daq_packetizer #(
  parameter int          BASE_PERIOD  = 500,
  parameter logic [15:0] SYNC_WORD    = 16'hA55A,
  parameter int          BUSY_TIMEOUT = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [2:0]  os_sel_i,
  input  logic        adc_busy_i,
  input  logic [15:0] adc_db_i,
  input  logic        fifo_afull_i,
  output logic [2:0]  adc_os_o,
  output logic        adc_convst_o,
  output logic        adc_cs_n_o,
  output logic        adc_rd_n_o,
  output logic        adc_reset_o,
  output logic [15:0] pkt_data_o,
  output logic        pkt_wr_o,
  output logic        pkt_eop_o,
  output logic        busy_err_o,
  output logic [15:0] drop_cnt_o
);

  localparam int TW = $clog2(BASE_PERIOD * 64 + 1);
  localparam int TB = $clog2(BUSY_TIMEOUT + 1);
  localparam int CW = (TB > 5) ? TB : 5;

  typedef enum logic [2:0] {
    IDLE, CONV, WAIT_HI, WAIT_LO, READ
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_clr;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] period;
  logic [2:0]    os_l;
  logic [2:0]    os_sat;
  logic [12:0]   frame_cnt;
  logic [12:0]   fc_l;
  logic [2:0]    rst_cnt;
  logic [15:0]   db_q;
  logic          hold;
  logic          tick;
  logic          idle_tick;
  logic          accept;
  logic          drop;
  logic          to_hit;

  assign os_sat    = (os_sel_i == 3'd7) ? 3'd6 : os_sel_i;
  assign period    = TW'(BASE_PERIOD) << os_l;
  assign hold      = !en_i || (rst_cnt != 3'd0);
  assign tick      = !hold && (timer_q == period - TW'(1));
  assign idle_tick = tick && (state_q == IDLE);
  assign accept    = idle_tick && !fifo_afull_i;
  assign drop      = idle_tick && fifo_afull_i;
  assign to_hit    = (cnt_q == CW'(BUSY_TIMEOUT - 1));

  // ADC reset stretch: one extra count keeps ticks off for a
  // cycle so the first frame lands a full period after the pulse.
  assign adc_reset_o = reset_i || (rst_cnt > 3'd1);
  assign adc_os_o    = os_l;

  // Post-reset ADC reset stretcher.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rst_cnt <= 3'd5;
    end else if (rst_cnt != 3'd0) begin
      rst_cnt <= rst_cnt - 3'd1;
    end
  end

  // Sample timer: free-runs while enabled, wraps every period.
  always_ff @(posedge clk_i) begin
    if (reset_i || hold) begin
      timer_q <= '0;
    end else if (timer_q >= period - TW'(1)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Frame bookkeeping: frame number, OS latch, drop counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cnt  <= '0;
      fc_l       <= '0;
      os_l       <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (idle_tick) begin
        frame_cnt <= frame_cnt + 13'd1;
      end
      if (accept) begin
        os_l <= os_sat;
        fc_l <= frame_cnt;
      end
      if (drop && (drop_cnt_o != 16'hFFFF)) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  // FSM state and shared phase counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_clr ? '0 : cnt_q + CW'(1);
    end
  end

  // Data capture at the end of rd_n low, sticky BUSY timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      db_q       <= '0;
      busy_err_o <= 1'b0;
    end else begin
      if (state_q == READ && cnt_q[1:0] == 2'd1) begin
        db_q <= adc_db_i;
      end
      if (state_q == WAIT_LO && adc_busy_i && to_hit) begin
        busy_err_o <= 1'b1;
      end
    end
  end

  // Next state and pin/packet outputs.
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    adc_convst_o = 1'b1;
    adc_cs_n_o   = 1'b1;
    adc_rd_n_o   = 1'b1;
    pkt_wr_o     = 1'b0;
    pkt_eop_o    = 1'b0;
    pkt_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (accept) begin
          state_d = CONV;
        end
      end
      CONV: begin
        adc_convst_o = 1'b0;
        pkt_wr_o     = 1'b1;
        pkt_data_o   = cnt_q[0] ? {os_l, fc_l} : SYNC_WORD;
        if (cnt_q[0]) begin
          state_d = WAIT_HI;
          cnt_clr = 1'b1;
        end
      end
      WAIT_HI: begin
        if (adc_busy_i || cnt_q[2:0] == 3'd7) begin
          state_d = WAIT_LO;
          cnt_clr = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!adc_busy_i || to_hit) begin
          state_d = READ;
          cnt_clr = 1'b1;
        end
      end
      READ: begin
        adc_cs_n_o = 1'b0;
        adc_rd_n_o = cnt_q[1];
        pkt_wr_o   = (cnt_q[1:0] == 2'd2);
        pkt_data_o = pkt_wr_o ? db_q : 16'd0;
        pkt_eop_o  = pkt_wr_o && (cnt_q[4:2] == 3'd7);
        if (cnt_q[4:0] == 5'd31) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_daq_packetizer.sv
// tb_daq_packetizer: randomized ADC model plus packet
// scoreboard for daq_packetizer.
module tb_daq_packetizer;

  localparam int BASE = 100;
  localparam int TO   = 300;
  localparam logic [15:0] SYNC = 16'hA55A;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        en_i = 1'b0;
  logic [2:0]  os_sel_i = 3'd0;
  logic        adc_busy_i = 1'b0;
  logic [15:0] adc_db_i = 16'd0;
  logic        fifo_afull_i = 1'b0;
  logic [2:0]  adc_os_o;
  logic        adc_convst_o;
  logic        adc_cs_n_o;
  logic        adc_rd_n_o;
  logic        adc_reset_o;
  logic [15:0] pkt_data_o;
  logic        pkt_wr_o;
  logic        pkt_eop_o;
  logic        busy_err_o;
  logic [15:0] drop_cnt_o;

  daq_packetizer #(
    .BASE_PERIOD (BASE),
    .SYNC_WORD   (SYNC),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .os_sel_i    (os_sel_i),
    .adc_busy_i  (adc_busy_i),
    .adc_db_i    (adc_db_i),
    .fifo_afull_i(fifo_afull_i),
    .adc_os_o    (adc_os_o),
    .adc_convst_o(adc_convst_o),
    .adc_cs_n_o  (adc_cs_n_o),
    .adc_rd_n_o  (adc_rd_n_o),
    .adc_reset_o (adc_reset_o),
    .pkt_data_o  (pkt_data_o),
    .pkt_wr_o    (pkt_wr_o),
    .pkt_eop_o   (pkt_eop_o),
    .busy_err_o  (busy_err_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        eop;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // controls owned by the main sequence
  bit stuck = 1'b0;
  int drops_set = 0;

  // ADC model state
  logic        p_conv = 1'b1;
  logic        p_rd = 1'b1;
  logic        p_ar = 1'b1;
  int          busy_left = 0;
  int          rd_idx = 0;
  int          falls = 0;
  int          last_fall = 0;
  int          rst_fall = 0;
  int          prev_os = 0;
  int          drops_used = 0;
  int          exp_fc = 0;
  int          m_os;
  int          m_pend;
  logic [12:0] m_fc;
  logic [15:0] m_db;
  bit          iv_ok = 1'b0;
  bit          first_tk = 1'b0;

  // ADC model: BUSY response, random conversion data, and
  // expected packet words pushed as the frame unfolds.
  always @(posedge clk) begin
    #1;
    if (reset_i) begin
      q.delete();
      adc_busy_i = 1'b0;
      busy_left  = 0;
      rd_idx     = 0;
      iv_ok      = 1'b0;
      first_tk   = 1'b0;
      exp_fc     = 0;
      drops_used = drops_set;
    end else begin
      if (p_ar && !adc_reset_o) begin
        rst_fall = cyc;
        first_tk = 1'b1;
      end
      if (!en_i) begin
        iv_ok    = 1'b0;
        first_tk = 1'b0;
      end
      if (p_conv && !adc_convst_o) begin
        m_os   = (os_sel_i == 3'd7) ? 6 : int'(os_sel_i);
        m_pend = drops_set - drops_used;
        m_fc   = 13'(exp_fc + m_pend);
        falls++;
        chk("os_pin", 32'(adc_os_o), m_os);
        if (iv_ok)
          chk("interval", cyc - last_fall,
              (BASE << prev_os) * (1 + m_pend));
        if (first_tk)
          chk("first_tick", cyc - rst_fall, BASE + 1);
        q.push_back('{SYNC, 1'b0, cyc});
        q.push_back('{{3'(m_os), m_fc}, 1'b0, cyc + 1});
        exp_fc     = (int'(m_fc) + 1) % 8192;
        drops_used = drops_set;
        prev_os    = m_os;
        last_fall  = cyc;
        iv_ok      = 1'b1;
        first_tk   = 1'b0;
        rd_idx     = 0;
      end
      if (!p_conv && adc_convst_o) begin
        adc_busy_i = 1'b1;
        busy_left  = $urandom_range(3, 40);
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (adc_busy_i && busy_left == 0 && !stuck)
        adc_busy_i = 1'b0;
      if (p_rd && !adc_rd_n_o) begin
        m_db     = 16'($urandom);
        adc_db_i = m_db;
        chk("cs_n", 32'(adc_cs_n_o), 0);
        q.push_back('{m_db, rd_idx == 7, cyc + 2});
        rd_idx++;
      end
    end
    p_conv = adc_convst_o;
    p_rd   = adc_rd_n_o;
    p_ar   = adc_reset_o;
  end

  int words = 0;
  int wcnt = 0;
  int last_len = 0;
  int pkts = 0;

  // Monitor: every FIFO write is checked against the queue head.
  always @(negedge clk) begin
    if (reset_i) begin
      wcnt = 0;
    end else if (pkt_wr_o) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL spurious_wr: got %h want no write (cycle %0d)",
                 pkt_data_o, cyc);
      end else begin
        e = q.pop_front();
        chk("word", {pkt_eop_o, pkt_data_o}, {e.eop, e.d});
        chk("word_cycle", cyc, e.at);
        words++;
        wcnt++;
        if (pkt_eop_o) begin
          last_len = wcnt;
          wcnt     = 0;
          pkts++;
        end
      end
    end
  end

  task automatic wait_falls(input int n, input int budget,
                            input string tag);
    int tgt = falls + n;
    int k = 0;
    while (falls < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (falls < tgt) begin
      total++;
      $display("FAIL timeout_%s: got %0d frames want %0d",
               tag, falls, tgt);
    end
  endtask

  task automatic wait_pkt(input int budget, input string tag);
    int p0 = pkts;
    int k = 0;
    while (pkts == p0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (pkts == p0) begin
      total++;
      $display("FAIL timeout_%s: got no EOP want one", tag);
    end
  endtask

  task automatic do_reset();
    int n = 0;
    @(posedge clk);
    #2 reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {adc_convst_o, adc_cs_n_o, adc_rd_n_o, adc_reset_o},
        4'hF);
    chk("rst_pkt", {pkt_wr_o, pkt_eop_o, pkt_data_o}, 0);
    chk("rst_os", 32'(adc_os_o), 0);
    chk("rst_err", 32'(busy_err_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    @(posedge clk);
    #2 reset_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!adc_reset_o) break;
      n++;
    end
    chk("adc_reset_len", n, 4);
  endtask

  int f0;
  int k0;

  initial begin
    en_i = 1'b1;
    do_reset();
    wait_falls(10, 1300, "nominal");

    os_sel_i = 3'd3;
    wait_falls(3, 2800, "os3");
    os_sel_i = 3'd7;
    wait_falls(2, 8000, "os7");
    os_sel_i = 3'd0;
    wait_falls(2, 7000, "os0");

    fifo_afull_i = 1'b1;
    f0 = falls;
    repeat (250) @(negedge clk);
    chk("afull_no_conv", falls, f0);
    drops_set    = 2;
    fifo_afull_i = 1'b0;
    chk("drop_cnt", 32'(drop_cnt_o), 2);
    wait_falls(2, 500, "after_drop");

    os_sel_i = 3'd3;
    wait_falls(1, 300, "pre_stuck");
    stuck = 1'b1;
    chk("err_before", 32'(busy_err_o), 0);
    wait_pkt(600, "stuck_pkt");
    chk("err_after", 32'(busy_err_o), 1);
    chk("stuck_len", last_len, 10);
    stuck    = 1'b0;
    os_sel_i = 3'd0;
    wait_falls(2, 1200, "post_stuck");

    k0 = 0;
    while (adc_cs_n_o && k0 < 300) begin
      @(negedge clk);
      k0++;
    end
    chk("reach_read", 32'(adc_cs_n_o), 0);
    en_i = 1'b0;
    wait_pkt(100, "en_drop_pkt");
    chk("en_drop_len", last_len, 10);
    f0 = falls;
    repeat (300) @(negedge clk);
    chk("en_low_no_conv", falls, f0);
    en_i = 1'b1;
    wait_falls(2, 400, "re_en");

    wait_falls(1, 200, "pre_rst");
    repeat (4) @(negedge clk);
    do_reset();
    wait_falls(3, 500, "post_rst");

    wait_pkt(200, "drain_pkt");
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
